// File: rtl/y86_pkg.sv
// ============================================================================
// Module      : y86_pkg
// Description : Shared Y86-64 instruction codes, register IDs and status codes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package y86_pkg;

    typedef enum logic [3:0] {
        I_HALT   = 4'h0,
        I_NOP    = 4'h1,
        I_RRMOVQ = 4'h2,
        I_IRMOVQ = 4'h3,
        I_RMMOVQ = 4'h4,
        I_MRMOVQ = 4'h5,
        I_OPQ    = 4'h6,
        I_JXX    = 4'h7,
        I_CALL   = 4'h8,
        I_RET    = 4'h9,
        I_PUSHQ  = 4'hA,
        I_POPQ   = 4'hB
    } icode_e;

    typedef enum logic [2:0] {
        S_AOK = 3'b001,
        S_INS = 3'b010,
        S_HLT = 3'b100
    } stat_e;

    localparam logic [3:0] R_RSP  = 4'h4;
    localparam logic [3:0] R_NONE = 4'hF;

    function automatic logic is_load(input logic [3:0] icode);
        return (icode == I_MRMOVQ) || (icode == I_POPQ);
    endfunction

endpackage

`default_nettype wire

// File: rtl/regfile_2r2w.sv
// ============================================================================
// Module      : regfile_2r2w
// Description : NREG x XLEN register file, two async reads + debug read,
//               two synchronous writes (M port wins on collision), async clear.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_2r2w #(
    parameter int XLEN = 64,
    parameter int NREG = 15
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [3:0]      ra_a_i,
    input  logic [3:0]      ra_b_i,
    input  logic [3:0]      dbg_sel_i,
    input  logic [3:0]      wa_e_i,
    input  logic [XLEN-1:0] wd_e_i,
    input  logic [3:0]      wa_m_i,
    input  logic [XLEN-1:0] wd_m_i,
    output logic [XLEN-1:0] rd_a_o,
    output logic [XLEN-1:0] rd_b_o,
    output logic [XLEN-1:0] dbg_data_o
);

    logic [XLEN-1:0] regs_q [NREG];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (wa_m_i == 4'(i))      regs_q[i] <= wd_m_i;
                else if (wa_e_i == 4'(i)) regs_q[i] <= wd_e_i;
            end
        end
    end

    // Address decode by compare keeps RNONE (and any ID >= NREG) reading as zero.
    always_comb begin
        rd_a_o     = '0;
        rd_b_o     = '0;
        dbg_data_o = '0;
        for (int i = 0; i < NREG; i++) begin
            if (ra_a_i == 4'(i))    rd_a_o     = regs_q[i];
            if (ra_b_i == 4'(i))    rd_b_o     = regs_q[i];
            if (dbg_sel_i == 4'(i)) dbg_data_o = regs_q[i];
        end
    end

endmodule

`default_nettype wire

// File: rtl/decode_stage.sv
// ============================================================================
// Module      : decode_stage
// Description : Y86-64 decode/writeback stage with forwarding, hazard control
//               and the D->E pipeline register.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module decode_stage
    import y86_pkg::*;
#(
    parameter int XLEN = 64,
    parameter int NREG = 15
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [2:0]      d_stat_i,
    input  logic [3:0]      d_icode_i,
    input  logic [3:0]      d_ifun_i,
    input  logic [3:0]      d_rA_i,
    input  logic [3:0]      d_rB_i,
    input  logic [XLEN-1:0] d_valC_i,
    input  logic [XLEN-1:0] d_valP_i,
    input  logic [3:0]      ex_dstE_i,
    input  logic [XLEN-1:0] ex_valE_i,
    input  logic            ex_cnd_i,
    input  logic [3:0]      m_icode_i,
    input  logic [3:0]      m_dstE_i,
    input  logic [3:0]      m_dstM_i,
    input  logic [XLEN-1:0] m_valE_i,
    input  logic [XLEN-1:0] m_valM_i,
    input  logic [3:0]      w_dstE_i,
    input  logic [3:0]      w_dstM_i,
    input  logic [XLEN-1:0] w_valE_i,
    input  logic [XLEN-1:0] w_valM_i,
    output logic [2:0]      e_stat_o,
    output logic [3:0]      e_icode_o,
    output logic [3:0]      e_ifun_o,
    output logic [XLEN-1:0] e_valC_o,
    output logic [XLEN-1:0] e_valA_o,
    output logic [XLEN-1:0] e_valB_o,
    output logic [3:0]      e_dstE_o,
    output logic [3:0]      e_dstM_o,
    output logic [3:0]      e_srcA_o,
    output logic [3:0]      e_srcB_o,
    output logic            f_stall_o,
    output logic            d_stall_o,
    output logic            d_bubble_o,
    input  logic [3:0]      dbg_sel_i,
    output logic [XLEN-1:0] dbg_data_o
);

    typedef struct packed {
        logic [2:0]      stat;
        logic [3:0]      icode;
        logic [3:0]      ifun;
        logic [XLEN-1:0] valc;
        logic [XLEN-1:0] vala;
        logic [XLEN-1:0] valb;
        logic [3:0]      dste;
        logic [3:0]      dstm;
        logic [3:0]      srca;
        logic [3:0]      srcb;
    } ereg_t;

    localparam ereg_t E_BUBBLE = '{stat: S_AOK, icode: I_NOP, ifun: 4'h0,
                                   valc: '0, vala: '0, valb: '0,
                                   dste: R_NONE, dstm: R_NONE,
                                   srca: R_NONE, srcb: R_NONE};

    ereg_t           e_q, e_d;
    logic [3:0]      src_a, src_b, dst_e, dst_m;
    logic [XLEN-1:0] rf_a, rf_b, val_a, val_b;
    logic            load_use, mispredict, ret_in_pipe;

    regfile_2r2w #(.XLEN(XLEN), .NREG(NREG)) u_rf (
        .clk        (clk),
        .rst_n      (rst_n),
        .ra_a_i     (src_a),
        .ra_b_i     (src_b),
        .dbg_sel_i  (dbg_sel_i),
        .wa_e_i     (w_dstE_i),
        .wd_e_i     (w_valE_i),
        .wa_m_i     (w_dstM_i),
        .wd_m_i     (w_valM_i),
        .rd_a_o     (rf_a),
        .rd_b_o     (rf_b),
        .dbg_data_o (dbg_data_o)
    );

    always_comb begin
        src_a = R_NONE;
        src_b = R_NONE;
        dst_e = R_NONE;
        dst_m = R_NONE;
        case (d_icode_i)
            I_RRMOVQ: begin src_a = d_rA_i; dst_e = d_rB_i; end
            I_IRMOVQ: dst_e = d_rB_i;
            I_RMMOVQ: begin src_a = d_rA_i; src_b = d_rB_i; end
            I_MRMOVQ: begin src_b = d_rB_i; dst_m = d_rA_i; end
            I_OPQ:    begin src_a = d_rA_i; src_b = d_rB_i; dst_e = d_rB_i; end
            I_CALL:   begin src_b = R_RSP; dst_e = R_RSP; end
            I_RET:    begin src_a = R_RSP; src_b = R_RSP; dst_e = R_RSP; end
            I_PUSHQ:  begin src_a = d_rA_i; src_b = R_RSP; dst_e = R_RSP; end
            I_POPQ:   begin src_a = R_RSP; src_b = R_RSP; dst_e = R_RSP; dst_m = d_rA_i; end
            default:  ;
        endcase
    end

    // A real source never equals RNONE, so an RNONE destination can never match.
    function automatic logic [XLEN-1:0] fwd(input logic [3:0] src, input logic [XLEN-1:0] rf);
        if (src == R_NONE)         return '0;
        else if (src == ex_dstE_i) return ex_valE_i;
        else if (src == m_dstM_i)  return m_valM_i;
        else if (src == m_dstE_i)  return m_valE_i;
        else if (src == w_dstM_i)  return w_valM_i;
        else if (src == w_dstE_i)  return w_valE_i;
        else                       return rf;
    endfunction

    always_comb begin
        val_a = fwd(src_a, rf_a);
        if (d_icode_i == I_CALL || d_icode_i == I_JXX) val_a = d_valP_i;
        val_b = fwd(src_b, rf_b);
    end

    assign load_use    = is_load(e_q.icode) && (e_q.dstm != R_NONE) &&
                         ((e_q.dstm == src_a) || (e_q.dstm == src_b));
    assign mispredict  = (e_q.icode == I_JXX) && !ex_cnd_i;
    assign ret_in_pipe = (d_icode_i == I_RET) || (e_q.icode == I_RET) || (m_icode_i == I_RET);

    assign f_stall_o  = rst_n & (load_use | ret_in_pipe);
    assign d_stall_o  = rst_n & load_use;
    assign d_bubble_o = rst_n & (mispredict | (ret_in_pipe & !load_use));

    always_comb begin
        e_d = '{stat: d_stat_i, icode: d_icode_i, ifun: d_ifun_i,
                valc: d_valC_i, vala: val_a, valb: val_b,
                dste: dst_e, dstm: dst_m, srca: src_a, srcb: src_b};
        if (mispredict || load_use) e_d = E_BUBBLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) e_q <= E_BUBBLE;
        else        e_q <= e_d;
    end

    assign e_stat_o  = e_q.stat;
    assign e_icode_o = e_q.icode;
    assign e_ifun_o  = e_q.ifun;
    assign e_valC_o  = e_q.valc;
    assign e_valA_o  = e_q.vala;
    assign e_valB_o  = e_q.valb;
    assign e_dstE_o  = e_q.dste;
    assign e_dstM_o  = e_q.dstm;
    assign e_srcA_o  = e_q.srca;
    assign e_srcB_o  = e_q.srcb;

endmodule

`default_nettype wire
